cp0_exc_unit: RTL

Coprocessor-0 exception/interrupt responder for the P7 pipeline; sits at the M stage and consumes the exception flags the E-stage ALU raises (arithmetic overflow, address-calculation overflow) plus earlier-stage exception codes and external hardware interrupts. It arbitrates these into a single exception request, records SR/Cause/EPC state, and serves `mfc0`/`mtc0`/`eret`. All architectural state is registered; the request and read paths are combinational from current state and inputs.

---
 rtl/cp0_exc_unit.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/cp0_exc_unit.sv
// CP0 exception/interrupt responder at the M stage: merges exception sources,
// raises a single flush/redirect request and holds SR, Cause and EPC.
module cp0_exc_unit #(
  parameter logic [31:0] PRID       = 32'h2023_0707,
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cp0_we,
  input  logic [4:0]  cp0_addr,
  input  logic [31:0] cp0_wdata,
  input  logic [31:0] vpc,
  input  logic        bd_in,
  input  logic [4:0]  exc_code_in,
  input  logic        exc_ariov,
  input  logic        exc_dmov,
  input  logic        is_store,
  input  logic [5:0]  hw_int,
  input  logic        exl_clr,
  output logic [31:0] cp0_rdata,
  output logic [31:0] epc_out,
  output logic        req,
  output logic [31:0] handler_pc
);

  localparam logic [4:0] AddrSr    = 5'd12;
  localparam logic [4:0] AddrCause = 5'd13;
  localparam logic [4:0] AddrEpc   = 5'd14;
  localparam logic [4:0] AddrPrid  = 5'd15;

  localparam logic [4:0] ExcOv   = 5'd12;
  localparam logic [4:0] ExcAdes = 5'd5;
  localparam logic [4:0] ExcAdel = 5'd4;

  // SR fields
  logic [5:0]  im_q, im_d;
  logic        exl_q, exl_d;
  logic        ie_q, ie_d;
  // Cause fields
  logic        bd_q, bd_d;
  logic [5:0]  ip_q, ip_d;
  logic [4:0]  exc_code_q, exc_code_d;
  // EPC
  logic [31:0] epc_q, epc_d;

  logic [4:0]  code;
  logic        int_req;
  logic        exc_req;
  logic [31:0] sr_word;
  logic [31:0] cause_word;

  // Merge exception sources; earlier stages take precedence over M-stage flags.
  always_comb begin
    if (exc_code_in != 5'd0) begin
      code = exc_code_in;
    end else if (exc_ariov) begin
      code = ExcOv;
    end else if (exc_dmov && is_store) begin
      code = ExcAdes;
    end else if (exc_dmov) begin
      code = ExcAdel;
    end else begin
      code = 5'd0;
    end
  end

  assign int_req    = ie_q & ~exl_q & (|(im_q & hw_int));
  assign exc_req    = (code != 5'd0) & ~exl_q;
  assign req        = int_req | exc_req;
  assign handler_pc = HANDLER_PC;
  assign epc_out    = epc_q;

  assign sr_word    = {16'd0, im_q, 8'd0, exl_q, ie_q};
  assign cause_word = {bd_q, 15'd0, ip_q, 3'd0, exc_code_q, 2'd0};

  // Next-state: a taken request overrides any mtc0 or eret in the same cycle.
  always_comb begin
    im_d       = im_q;
    exl_d      = exl_q;
    ie_d       = ie_q;
    bd_d       = bd_q;
    ip_d       = hw_int;
    exc_code_d = exc_code_q;
    epc_d      = epc_q;
    if (req) begin
      exl_d      = 1'b1;
      exc_code_d = int_req ? 5'd0 : code;
      bd_d       = bd_in;
      epc_d      = bd_in ? (vpc - 32'd4) : vpc;
    end else begin
      if (cp0_we) begin
        if (cp0_addr == AddrSr) begin
          im_d  = cp0_wdata[15:10];
          exl_d = cp0_wdata[1];
          ie_d  = cp0_wdata[0];
        end else if (cp0_addr == AddrEpc) begin
          epc_d = cp0_wdata;
        end
      end
      // eret lands after any same-cycle SR write
      if (exl_clr) begin
        exl_d = 1'b0;
      end
    end
  end

  // Architectural state with asynchronous active-low clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      im_q       <= 6'd0;
      exl_q      <= 1'b0;
      ie_q       <= 1'b0;
      bd_q       <= 1'b0;
      ip_q       <= 6'd0;
      exc_code_q <= 5'd0;
      epc_q      <= 32'd0;
    end else begin
      im_q       <= im_d;
      exl_q      <= exl_d;
      ie_q       <= ie_d;
      bd_q       <= bd_d;
      ip_q       <= ip_d;
      exc_code_q <= exc_code_d;
      epc_q      <= epc_d;
    end
  end

  // Read mux over current registered state.
  always_comb begin
    cp0_rdata = 32'd0;
    unique case (cp0_addr)
      AddrSr:    cp0_rdata = sr_word;
      AddrCause: cp0_rdata = cause_word;
      AddrEpc:   cp0_rdata = epc_q;
      AddrPrid:  cp0_rdata = PRID;
      default:   cp0_rdata = 32'd0;
    endcase
  end

endmodule
